// File: rtl/kernel_pingpong.sv
// Double-buffered kernel row store: bank W fills from the kernel stream while bank R feeds the array.
// Optional macro KERNEL_BIAS_EN latches row 0 of R onto bias_bus at read start-up.
module kernel_pingpong #(
    parameter int                    CFG_DWIDTH    = 32,
    parameter int                    CFG_AWIDTH    = 5,
    parameter logic [CFG_AWIDTH-1:0] CFG_KER_WR    = 5'd8,
    parameter logic [CFG_AWIDTH-1:0] CFG_KER_RD    = 5'd9,
    parameter logic [CFG_AWIDTH-1:0] CFG_KER_SWAP  = 5'd10,
    parameter int                    STR_KER_WIDTH = 16,
    parameter int                    GROUP_NB      = 4,
    parameter int                    DEPTH_NB      = 1,
    parameter int                    KER_WIDTH     = 16,
    parameter int                    MEM_AWIDTH    = 8,
    parameter int                    MEM_DEPTH     = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [CFG_DWIDTH-1:0]                   cfg_data,
    input  logic [CFG_AWIDTH-1:0]                   cfg_addr,
    input  logic                                    cfg_valid,
    input  logic [STR_KER_WIDTH-1:0]                str_ker,
    input  logic                                    str_ker_val,
    output logic                                    str_ker_rdy,
    output logic [GROUP_NB*DEPTH_NB*KER_WIDTH-1:0]  bias_bus,
    output logic [GROUP_NB*DEPTH_NB*KER_WIDTH-1:0]  kernel_bus,
    output logic                                    kernel_val,
    input  logic                                    kernel_rdy
);

    localparam int LANES = GROUP_NB * DEPTH_NB;
    localparam int ROW_W = LANES * KER_WIDTH;
    localparam int PACK  = STR_KER_WIDTH / KER_WIDTH;
    localparam int BEATS = LANES / PACK;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [BW-1:0]         BEAT_LAST = BW'(BEATS - 1);
    localparam logic [MEM_AWIDTH-1:0] ROW_LAST  = MEM_AWIDTH'(MEM_DEPTH - 1);

    typedef enum logic {
        FILL_IDLE,
        FILL_ACTIVE
    } fill_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_LOAD,
        RD_FETCH,
        RD_RUN
    } rd_state_t;

    fill_state_t fill_state, fill_nxt;
    rd_state_t   rd_state, rd_nxt;

    logic [ROW_W-1:0] mem [2][MEM_DEPTH];

    logic                  wr_cmd, rd_cmd, sw_cmd;
    logic                  wr_bank, rd_bank;
    logic [1:0]            full;
    logic                  swap_pend, swap_go, reload;
    logic [MEM_AWIDTH-1:0] wr_row, wr_end;
    logic [BW-1:0]         beat_cnt;
    logic [ROW_W-1:0]      row_buf, row_next;
    logic                  beat, row_done, fill_done;
    logic [MEM_AWIDTH-1:0] rd_start, rd_end, rd_addr, rd_addr_nxt;
    logic                  rd_cfg, fetch_ok, accept;
    logic [ROW_W-1:0]      kbus_q;
    logic                  cfg_unused;

    assign cfg_unused = ^cfg_data;

    assign wr_cmd = cfg_valid && (cfg_addr == CFG_KER_WR);
    assign rd_cmd = cfg_valid && (cfg_addr == CFG_KER_RD);
    assign sw_cmd = cfg_valid && (cfg_addr == CFG_KER_SWAP);

    assign rd_bank     = ~wr_bank;
    assign str_ker_rdy = (fill_state == FILL_ACTIVE);
    assign beat        = str_ker_rdy && str_ker_val;
    assign row_done    = beat && (beat_cnt == BEAT_LAST);
    assign fill_done   = row_done && (wr_row == wr_end);

    // Swap uses the registered pending flag, so a command landing on the fill-completion edge executes one edge later.
    assign swap_go = swap_pend && (fill_state == FILL_IDLE) && full[wr_bank];
    assign reload  = rd_cmd || swap_go;

    // ---------------- fill side ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fill_state <= FILL_IDLE;
        else        fill_state <= fill_nxt;
    end

    always_comb begin
        fill_nxt = fill_state;
        if (wr_cmd)         fill_nxt = FILL_ACTIVE;
        else if (fill_done) fill_nxt = FILL_IDLE;
    end

    always_comb begin
        row_next = row_buf;
        row_next[32'(beat_cnt) * STR_KER_WIDTH +: STR_KER_WIDTH] = str_ker;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_row   <= '0;
            wr_end   <= '0;
            beat_cnt <= '0;
            row_buf  <= '0;
        end else if (wr_cmd) begin
            wr_row   <= '0;
            wr_end   <= cfg_data[MEM_AWIDTH-1:0];
            beat_cnt <= '0;
        end else if (beat) begin
            row_buf <= row_next;
            if (row_done) begin
                beat_cnt <= '0;
                wr_row   <= wr_row + 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (row_done && !wr_cmd)
            mem[wr_bank][wr_row[IW-1:0]] <= row_next;
    end

    // ---------------- bank roles and flags ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            full      <= '0;
            swap_pend <= 1'b0;
        end else begin
            if (swap_go) begin
                wr_bank       <= ~wr_bank;
                full[rd_bank] <= 1'b0;
            end
            if (wr_cmd && !swap_go)
                full[wr_bank] <= 1'b0;
            else if (fill_done)
                full[wr_bank] <= 1'b1;
            if (sw_cmd)       swap_pend <= 1'b1;
            else if (swap_go) swap_pend <= 1'b0;
        end
    end

    // ---------------- read side ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_start <= '0;
            rd_end   <= '0;
            rd_cfg   <= 1'b0;
        end else if (rd_cmd) begin
            rd_start <= cfg_data[MEM_AWIDTH-1:0];
            rd_end   <= cfg_data[16 +: MEM_AWIDTH];
            rd_cfg   <= 1'b1;
        end
    end

    assign fetch_ok   = full[rd_bank] && rd_cfg;
    assign kernel_val = (rd_state == RD_RUN) && fetch_ok;
    assign accept     = kernel_val && kernel_rdy;
    assign kernel_bus = kbus_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= RD_IDLE;
        else        rd_state <= rd_nxt;
    end

    always_comb begin
        rd_nxt = rd_state;
        if (reload) begin
            rd_nxt = RD_LOAD;
        end else begin
            case (rd_state)
                RD_LOAD:  rd_nxt = RD_FETCH;
                RD_FETCH: rd_nxt = fetch_ok ? RD_RUN : RD_IDLE;
                RD_RUN:   if (!fetch_ok) rd_nxt = RD_IDLE;
                default:  rd_nxt = rd_state;
            endcase
        end
    end

    // rd_addr runs one row ahead of kernel_bus, so the wrap test is applied to the prefetched address.
    always_comb begin
        rd_addr_nxt = rd_addr + 1'b1;
        if (rd_addr == rd_end)        rd_addr_nxt = rd_start;
        else if (rd_addr == ROW_LAST) rd_addr_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
            kbus_q  <= '0;
        end else begin
            case (rd_state)
                RD_LOAD: rd_addr <= rd_start;
                RD_FETCH: begin
                    if (fetch_ok) begin
                        kbus_q  <= mem[rd_bank][rd_addr[IW-1:0]];
                        rd_addr <= rd_addr_nxt;
                    end
                end
                RD_RUN: begin
                    if (accept) begin
                        kbus_q  <= mem[rd_bank][rd_addr[IW-1:0]];
                        rd_addr <= rd_addr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KERNEL_BIAS_EN
    logic [ROW_W-1:0] bias_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bias_q <= '0;
        else if ((rd_state == RD_FETCH) && fetch_ok)
            bias_q <= mem[rd_bank][0];
    end

    assign bias_bus = bias_q;
`else
    assign bias_bus = '0;
`endif

endmodule

// File: doc/kernel_pingpong.md
# kernel_pingpong

Double-buffered kernel/bias store for the convolution engine. It sits between the kernel stream input and the multiplier array. One bank is filled from the kernel stream while the other bank feeds `kernel_bus`/`bias_bus` to the array. Both banks are programmed over the shared configuration bus. Bank roles swap on command, so the next layer's kernels load while the current layer computes.

## Interface
Parameters:
- `CFG_DWIDTH`, 32: config data width.
- `CFG_AWIDTH`, 5: config address width.
- `CFG_KER_WR`, 5'd8: config address for the write command.
- `CFG_KER_RD`, 5'd9: config address for the read command.
- `CFG_KER_SWAP`, 5'd10: config address for the bank-swap command.
- `STR_KER_WIDTH`, 16: stream beat width; must be a multiple of `KER_WIDTH`. PACK = `STR_KER_WIDTH`/`KER_WIDTH`.
- `GROUP_NB`, 4; `DEPTH_NB`, 1: LANES = `GROUP_NB`*`DEPTH_NB`. PACK must divide LANES.
- `KER_WIDTH`, 16: width of one kernel value.
- `MEM_AWIDTH`, 8; `MEM_DEPTH`, 8: rows per bank. `MEM_DEPTH` ≤ 2^`MEM_AWIDTH`.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cfg_data`  in  `CFG_DWIDTH`: config payload.
- `cfg_addr`  in  `CFG_AWIDTH`: config register select.
- `cfg_valid`  in  1: config strobe, one cycle per command.
- `str_ker`  in  `STR_KER_WIDTH`: kernel stream data.
- `str_ker_val`  in  1: stream valid.
- `str_ker_rdy`  out  1: stream ready.
- `bias_bus`  out  LANES*`KER_WIDTH`: bias row of the read bank.
- `kernel_bus`  out  LANES*`KER_WIDTH`: current kernel row.
- `kernel_val`  out  1: `kernel_bus` holds a valid row.
- `kernel_rdy`  in  1: consumer accepts the current row.

## Operation
- **Storage:** two banks (W = write bank, R = read bank), each `MEM_DEPTH` rows × LANES*`KER_WIDTH` bits. Each bank has a full flag. After reset, bank0 = W, both banks are empty, and no read region is configured.
- **Write command:** `CFG_KER_WR`, wr_end = `cfg_data[MEM_AWIDTH-1:0]`. Arms a fill of W, rows 0..wr_end, clears W's full flag, and resets the write pointer to row 0, lane 0. A new write command during an active fill restarts the fill.
- **Filling:** a beat transfers when `str_ker_val` && `str_ker_rdy`. Each beat fills PACK lanes; the lowest `KER_WIDTH` bits of the beat go to the lowest lane. The first beat of a row lands in lane 0, which is the LSBs of the bus. After LANES/PACK beats the row is written and the pointer moves to the next row. When row wr_end completes, the fill ends, `str_ker_rdy` drops, and W's full flag is set.
- **Read command:** `CFG_KER_RD`, `cfg_data` = {end[31:16], start[15:0]}; only the low `MEM_AWIDTH` bits of each field are used. Read address is loaded with start and the outputs are reloaded from R.
- **Read advance:** on each accept (`kernel_val` && `kernel_rdy`), address = (address+1) mod `MEM_DEPTH`, except that after end it returns to start.
  - start > end wraps through row `MEM_DEPTH`-1 to row 0. Example: start 6, end 1 gives 6,7,0,1,6,…
  - start == end holds one row.
- **Swap command:** `CFG_KER_SWAP` sets swap_pend.
  - The swap executes on the first edge where swap_pend = 1, no fill is active, and W is full.
  - On execution: banks exchange roles, the new W's full flag clears, the read address reloads the configured start, and swap_pend clears.
- **kernel_val:** 1 only while R is full and a read region is configured.
- **Simultaneous events:**
  - Swap command in the same cycle as fill completion: the swap executes on the following edge.
  - Read command and swap in the same cycle: the read fields apply to the post-swap R.
  - Stream beats arriving while no fill is active are not accepted (`str_ker_rdy` = 0).
  - Unknown `cfg_addr` values are ignored.

## Timing
- **Reset values:** `str_ker_rdy` 0, `kernel_val` 0, `kernel_bus` 0, `bias_bus` 0. All flags and pointers clear. Asserting reset mid-fill or mid-read aborts immediately.
- **Write side:** `str_ker_rdy` rises the cycle after the `CFG_KER_WR` edge. It falls the cycle after the last beat is accepted. One beat per cycle at full rate.
- **Read or swap start-up:** `kernel_val` rises 2 cycles after the read-command edge or swap-execution edge (address load, then synchronous memory read). It is 0 in between.
- **Read throughput:** after an accept, the next row is on `kernel_bus` at the next edge. Back-to-back `kernel_rdy` gives one row per cycle with no bubbles (prefetch addressing). With `kernel_rdy` = 0, `kernel_bus` holds.
- **bias_bus:** updates together with the first valid `kernel_bus` after a read command or swap.

## Configuration
- `KERNEL_BIAS_EN` defined:
  - Row 0 of R is latched onto `bias_bus` at read start-up and held until the next read command or swap.
  - Row 0 remains addressable as a kernel row.
- `KERNEL_BIAS_EN` undefined: `bias_bus` is constant 0 and no bias register is built.

## Test plan
Defaults throughout; `str_ker` counts 1..32.
- **Fill:** `CFG_KER_WR` with 7, then 32 beats, then `CFG_KER_SWAP` → `str_ker_rdy` 1 for exactly 32 accepted beats. Two cycles after the swap executes: `kernel_bus` = 0x0004_0003_0002_0001 (read cfg start 0, end 7). With `KERNEL_BIAS_EN`, `bias_bus` = the same value.
- **Read region:** read cfg {5,1}, `kernel_rdy` held for 7 cycles → rows 1,2,3,4,5,1,2. Row 1 = 0x0008_0007_0006_0005. Dropping `kernel_rdy` for a cycle holds the row.
- **Wrap:** read cfg {1,6}, continuous `kernel_rdy` → rows 6,7,0,1,6.
- **Overlap:** refill W (beats 101..132) while R is being read continuously → R output is unchanged and unstalled throughout the fill. After swap + 2 cycles, row 0 = 0x0068_0067_0066_0065.
- **Pending swap:** `CFG_KER_SWAP` issued mid-fill → no swap until the last beat, then a swap on the next edge. `kernel_val` goes 0 for 2 cycles, then 1.
- **Reset mid-fill:** drive `rst_n` low after 10 beats → all outputs 0 asynchronously. After release, `str_ker_rdy` = 0 until a new `CFG_KER_WR`, and `kernel_val` = 0.
